alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- ID/EX issue stage that sits directly upstream of the 32-bit MIPS ALU.
- Accepts a decoded R-type instruction word plus its register-file operand values through a valid/ready handshake.
- Maps funct/shamt/rs/rt onto the ALU's in0/in1/op inputs.
- Buffers results in a 2-entry skid FIFO so that ALU-side stalls do not create a combinational ready path back to decode.

Parameters:
- DROP_NOP, 0: when 1, instruction word 32'h00000000 is consumed and discarded (not enqueued, illegal not raised).
- DEPTH, 2: FIFO entries. Fixed at 2; any other value is unsupported.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  discards all buffered entries and the current input.
- in_valid  input  1  upstream offers an instruction.
- in_ready  output  1  stage can accept; registered, equals (count<2).
- in_instr  input  32  MIPS instruction word.
- in_rs_val  input  32  value of GPR[rs].
- in_rt_val  input  32  value of GPR[rt].
- out_valid  output  1  head entry valid toward the ALU.
- out_ready  input  1  ALU/EX consumes the head entry.
- alu_in0  output  32  ALU operand 0.
- alu_in1  output  32  ALU operand 1.
- alu_op  output  11  ALU op code, {5'b0, funct}.
- out_rd  output  5  destination register of the head entry.
- illegal  output  1  one-cycle pulse: an unsupported instruction was accepted and dropped.

Behaviour:
- Reset (async, rst=1):
  - count=0; out_valid=0; in_ready=1; illegal=0.
  - alu_in0, alu_in1, alu_op, out_rd all 0; storage cleared.
  - Takes effect immediately mid-operation; buffered entries are lost.
- Acceptance: fires when in_valid && in_ready. in_instr and operands are sampled on that edge only.
- Legality:
  - opcode in_instr[31:26] must be 0.
  - funct must be one of: 0x20, 0x21, 0x22, 0x23, 0x24, 0x25, 0x26, 0x27, 0x2A, 0x2B, 0x00, 0x02, 0x03, 0x04, 0x06, 0x07.
  - Otherwise the instruction is accepted, not enqueued, and illegal=1 on the following cycle for exactly one cycle.
- Operand mapping:
  - Arithmetic, logic, slt, sltu (funct 0x20–0x2B): in0=rs_val, in1=rt_val.
  - Immediate shifts (0x00, 0x02, 0x03): in0=rt_val, in1={27'b0, shamt[10:6]}.
  - Variable shifts (0x04, 0x06, 0x07): in0=rt_val, in1={27'b0, rs_val[4:0]}.
  - All legal instructions: op={5'b0, funct}; rd=in_instr[15:11].
- Latency: 1 cycle. An entry accepted at edge N is visible at the outputs (out_valid=1) after edge N; there is no combinational bypass.
- Pop: fires when out_valid && out_ready; the head advances on that edge.
- Empty outputs: when count=0, out_valid=0 and alu_in0, alu_in1, alu_op, out_rd are driven 0.
- Count rules:
  - Push without pop: count+1.
  - Pop without push: count-1.
  - Push and pop together at count=1: count stays 1; the new entry becomes the head.
  - Push is impossible at count=2 (in_ready=0).
  - Pop at count=2: count=1, and in_ready=1 on the next cycle.
- Ordering: strict FIFO; a dropped illegal instruction or NOP does not disturb the order of other entries.
- Flush:
  - Next cycle: count=0, out_valid=0, in_ready=1.
  - An input handshaking in the same cycle is discarded, and illegal is suppressed for it.
  - A pop in the same cycle is still considered consumed by downstream.
- Simultaneous flush and reset: reset dominates.

Test Plan:
- Basic add: in_instr=0x00221820 (add $3,$1,$2), rs_val=5, rt_val=7, out_ready=1 -> next cycle out_valid=1, alu_in0=5, alu_in1=7, alu_op=0x020, out_rd=3; one cycle later out_valid=0.
- Shift mapping:
  - sll: 0x00022080 with rt_val=0x0000000F -> alu_in0=0xF, alu_in1=2, alu_op=0x000, out_rd=4.
  - sllv: 0x00222804 with rs_val=0x23 -> alu_in1=3, alu_op=0x004, out_rd=5.
- Illegal: 0x00220018 (mult) -> illegal=1 for one cycle, out_valid stays 0. 0x20220005 (addi) -> same response. With DROP_NOP=1, 0x00000000 -> no illegal, no entry.
- Backpressure:
  - out_ready=0; offer add, sub, and instructions back-to-back.
  - in_ready drops to 0 after the second acceptance; the third is held by upstream.
  - Then raise out_ready=1 -> outputs appear in order add, sub, and, one per cycle, with no loss.
- Flush with count=2 and in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1, illegal=0; the flushed instruction is never output.
- Reset mid-stream: assert rst asynchronously between edges with count=2 -> out_valid=0, in_ready=1, all data outputs 0 immediately; after release, a fresh add issues with 1-cycle latency.

Source files
------------

// File: rtl/alu_issue_if.sv
// alu_issue_if: decode-side and ALU-side handshake bundle for the issue stage
interface alu_issue_if;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_in0;
  logic [31:0] alu_in1;
  logic [10:0] alu_op;
  logic [4:0]  out_rd;
  logic        illegal;
  modport slave (
    input  flush, in_valid, in_instr, in_rs_val, in_rt_val, out_ready,
    output in_ready, out_valid, alu_in0, alu_in1, alu_op, out_rd, illegal
  );
  modport master (
    output flush, in_valid, in_instr, in_rs_val, in_rt_val, out_ready,
    input  in_ready, out_valid, alu_in0, alu_in1, alu_op, out_rd, illegal
  );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: maps R-type instructions onto ALU operands through a 2-entry skid FIFO
module alu_issue_stage #(
  parameter bit DROP_NOP = 1'b0,
  parameter int DEPTH    = 2
) (
  input logic        clk,
  input logic        rst,
  alu_issue_if.slave bus
);
  typedef struct packed {
    logic [31:0] in0;
    logic [31:0] in1;
    logic [5:0]  funct;
    logic [4:0]  rd;
  } entry_t;
  entry_t     mem_q [2];
  entry_t     ent_d;
  entry_t     head;
  logic [1:0] count_q, count_d;
  logic       head_q, head_d, tail_q, tail_d;
  logic       illegal_q, illegal_d;
  logic [5:0] funct;
  logic       legal, nop, accept, push, pop;
  assign funct  = bus.in_instr[5:0];
  assign legal  = bus.in_instr[31:26] == 6'd0 &&
                  (funct[5] ? (funct[4:3] == 2'b00 || funct[4:1] == 4'b0101)
                            : (funct[4:3] == 2'b00 && funct[1:0] != 2'b01));
  assign nop    = DROP_NOP && bus.in_instr == 32'd0;
  assign accept = bus.in_valid && bus.in_ready;
  assign pop    = bus.out_valid && bus.out_ready;
  // Operand mapping and FIFO pointer/count update; flush wins over any push
  always_comb begin
    push      = accept && !bus.flush && legal && !nop;
    illegal_d = accept && !bus.flush && !legal;
    ent_d.funct = funct;
    ent_d.rd    = bus.in_instr[15:11];
    ent_d.in0   = funct[5] ? bus.in_rs_val : bus.in_rt_val;
    ent_d.in1   = funct[5] ? bus.in_rt_val
                           : {27'd0, funct[2] ? bus.in_rs_val[4:0] : bus.in_instr[10:6]};
    count_d = bus.flush ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
    head_d  = !bus.flush && (head_q ^ pop);
    tail_d  = !bus.flush && (tail_q ^ push);
  end
  // FIFO state, storage and the one-cycle illegal pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= 2'd0;
      head_q    <= 1'b0;
      tail_q    <= 1'b0;
      illegal_q <= 1'b0;
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
    end else begin
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      illegal_q <= illegal_d;
      if (push) mem_q[tail_q] <= ent_d;
    end
  end
  assign head          = mem_q[head_q];
  assign bus.out_valid = count_q != 2'd0;
  assign bus.in_ready  = count_q < 2'(DEPTH);
  assign bus.alu_in0   = bus.out_valid ? head.in0 : 32'd0;
  assign bus.alu_in1   = bus.out_valid ? head.in1 : 32'd0;
  assign bus.alu_op    = bus.out_valid ? {5'd0, head.funct} : 11'd0;
  assign bus.out_rd    = bus.out_valid ? head.rd : 5'd0;
  assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: vector table plus corner sequences, scoreboard-checked outputs
module tb_alu_issue_stage;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  always #5 clk = ~clk;
  alu_issue_if b ();
  alu_issue_if n ();
  alu_issue_stage #(.DROP_NOP(1'b0)) dut (.clk(clk), .rst(rst), .bus(b));
  alu_issue_stage #(.DROP_NOP(1'b1)) dut_n (.clk(clk), .rst(rst), .bus(n));
  typedef struct {
    logic [31:0] in0;
    logic [31:0] in1;
    logic [10:0] op;
    logic [4:0]  rd;
  } exp_t;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs;
    logic [31:0] rt;
    bit          enq;
    bit          ill;
    logic [31:0] in0;
    logic [31:0] in1;
    logic [10:0] op;
    logic [4:0]  rd;
  } vec_t;
  exp_t sb[$];
  exp_t e;
  vec_t vt[13];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
    b.in_valid  = 1'b1;
    b.in_instr  = i;
    b.in_rs_val = rs;
    b.in_rt_val = rt;
  endtask
  task automatic expect_out(input logic [31:0] in0, input logic [31:0] in1, input logic [10:0] op, input logic [4:0] rd);
    sb.push_back('{in0, in1, op, rd});
  endtask
  always @(negedge clk) begin
    if (!rst && b.out_valid && b.out_ready) begin
      if (sb.size() == 0) chk("unexpected_out", b.alu_op, 32'hFFFF_FFFF);
      else begin
        e = sb.pop_front();
        chk("alu_in0", b.alu_in0, e.in0);
        chk("alu_in1", b.alu_in1, e.in1);
        chk("alu_op", b.alu_op, e.op);
        chk("out_rd", b.out_rd, e.rd);
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end
  initial begin
    vt[0]  = '{32'h00221820, 32'd5, 32'd7, 1, 0, 32'd5, 32'd7, 11'h020, 5'd3};
    vt[1]  = '{32'h00022080, 32'h99, 32'hF, 1, 0, 32'hF, 32'd2, 11'h000, 5'd4};
    vt[2]  = '{32'h00222804, 32'h23, 32'h12345678, 1, 0, 32'h12345678, 32'd3, 11'h004, 5'd5};
    vt[3]  = '{32'h00432022, 32'd10, 32'd3, 1, 0, 32'd10, 32'd3, 11'h022, 5'd4};
    vt[4]  = '{32'h000312C3, 32'hFFFF, 32'h80000000, 1, 0, 32'h80000000, 32'd11, 11'h003, 5'd2};
    vt[5]  = '{32'h00A31007, 32'hFFFFFFE4, 32'hCAFEBABE, 1, 0, 32'hCAFEBABE, 32'd4, 11'h007, 5'd2};
    vt[6]  = '{32'h0062F82B, 32'd1, 32'd2, 1, 0, 32'd1, 32'd2, 11'h02B, 5'd31};
    vt[7]  = '{32'h00220018, 32'd1, 32'd2, 0, 1, 32'd0, 32'd0, 11'h0, 5'd0};
    vt[8]  = '{32'h20220005, 32'd1, 32'd2, 0, 1, 32'd0, 32'd0, 11'h0, 5'd0};
    vt[9]  = '{32'h00221801, 32'd1, 32'd2, 0, 1, 32'd0, 32'd0, 11'h0, 5'd0};
    vt[10] = '{32'h00221828, 32'd1, 32'd2, 0, 1, 32'd0, 32'd0, 11'h0, 5'd0};
    vt[11] = '{32'h00221827, 32'hF0F0, 32'h0FF0, 1, 0, 32'hF0F0, 32'h0FF0, 11'h027, 5'd3};
    vt[12] = '{32'h00000000, 32'd9, 32'h55, 1, 0, 32'h55, 32'd0, 11'h000, 5'd0};
    b.flush = 0; b.in_valid = 0; b.in_instr = 0; b.in_rs_val = 0; b.in_rt_val = 0; b.out_ready = 1;
    n.flush = 0; n.in_valid = 0; n.in_instr = 0; n.in_rs_val = 0; n.in_rt_val = 0; n.out_ready = 1;
    #12;
    chk("rst_out_valid", b.out_valid, 0);
    chk("rst_in_ready", b.in_ready, 1);
    chk("rst_illegal", b.illegal, 0);
    chk("rst_alu_in0", b.alu_in0, 0);
    cyc();
    rst = 1'b0;
    cyc();
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].instr, vt[i].rs, vt[i].rt);
      if (vt[i].enq) expect_out(vt[i].in0, vt[i].in1, vt[i].op, vt[i].rd);
      chk("pre_out_valid", b.out_valid, 0);
      cyc();
      b.in_valid = 1'b0;
      chk($sformatf("v%0d_out_valid", i), b.out_valid, vt[i].enq);
      chk($sformatf("v%0d_illegal", i), b.illegal, vt[i].ill);
      cyc();
      chk($sformatf("v%0d_out_valid_after", i), b.out_valid, 0);
      chk($sformatf("v%0d_illegal_after", i), b.illegal, 0);
    end
    b.out_ready = 1'b0;
    drive(32'h00221820, 32'd5, 32'd7);
    expect_out(32'd5, 32'd7, 11'h020, 5'd3);
    cyc();
    chk("bp_in_ready1", b.in_ready, 1);
    drive(32'h00432022, 32'd10, 32'd3);
    expect_out(32'd10, 32'd3, 11'h022, 5'd4);
    cyc();
    chk("bp_in_ready2", b.in_ready, 0);
    drive(32'h00221824, 32'hF0F0, 32'hFF00);
    cyc();
    chk("bp_hold_in_ready", b.in_ready, 0);
    chk("bp_head_op", b.alu_op, 11'h020);
    expect_out(32'hF0F0, 32'hFF00, 11'h024, 5'd3);
    b.out_ready = 1'b1;
    begin
      bit acc = 0;
      for (int i = 0; i < 10 && !acc; i++) begin
        acc = b.in_ready;
        cyc();
      end
      b.in_valid = 1'b0;
      chk("bp_accept", acc, 1);
    end
    chk("bp_and_head_valid", b.out_valid, 1);
    chk("bp_and_head_op", b.alu_op, 11'h024);
    cyc();
    chk("bp_drained", b.out_valid, 0);
    chk("bp_sb_empty", sb.size(), 0);
    b.out_ready = 1'b0;
    drive(32'h00221820, 32'd1, 32'd1);
    cyc();
    drive(32'h00432022, 32'd2, 32'd2);
    cyc();
    chk("fl_full", b.in_ready, 0);
    drive(32'h0062F82B, 32'd3, 32'd3);
    b.flush = 1'b1;
    cyc();
    b.flush = 1'b0;
    b.in_valid = 1'b0;
    chk("fl_out_valid", b.out_valid, 0);
    chk("fl_in_ready", b.in_ready, 1);
    chk("fl_illegal", b.illegal, 0);
    drive(32'h00220018, 32'd0, 32'd0);
    b.flush = 1'b1;
    cyc();
    b.flush = 1'b0;
    b.in_valid = 1'b0;
    chk("fl_ill_suppressed", b.illegal, 0);
    chk("fl_ill_out_valid", b.out_valid, 0);
    b.out_ready = 1'b1;
    drive(32'h00221820, 32'd8, 32'd9);
    expect_out(32'd8, 32'd9, 11'h020, 5'd3);
    cyc();
    b.in_valid = 1'b0;
    chk("fl_fresh_valid", b.out_valid, 1);
    cyc();
    chk("fl_sb_empty", sb.size(), 0);
    b.out_ready = 1'b0;
    drive(32'h00221820, 32'd1, 32'd1);
    cyc();
    drive(32'h00432022, 32'd2, 32'd2);
    cyc();
    b.in_valid = 1'b0;
    chk("rs_full", b.in_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("rs_out_valid", b.out_valid, 0);
    chk("rs_in_ready", b.in_ready, 1);
    chk("rs_alu_in0", b.alu_in0, 0);
    chk("rs_alu_in1", b.alu_in1, 0);
    chk("rs_alu_op", b.alu_op, 0);
    chk("rs_out_rd", b.out_rd, 0);
    cyc();
    rst = 1'b0;
    b.out_ready = 1'b1;
    drive(32'h00221820, 32'd5, 32'd7);
    expect_out(32'd5, 32'd7, 11'h020, 5'd3);
    cyc();
    b.in_valid = 1'b0;
    chk("rs_fresh_valid", b.out_valid, 1);
    chk("rs_fresh_in0", b.alu_in0, 5);
    cyc();
    chk("rs_fresh_gone", b.out_valid, 0);
    n.in_valid = 1'b1;
    n.in_instr = 32'h0;
    n.in_rt_val = 32'h55;
    cyc();
    chk("nop_illegal", n.illegal, 0);
    chk("nop_out_valid", n.out_valid, 0);
    chk("nop_in_ready", n.in_ready, 1);
    n.in_instr = 32'h00221820;
    n.in_rs_val = 32'd5;
    n.in_rt_val = 32'd7;
    cyc();
    n.in_valid = 1'b0;
    chk("nop_add_valid", n.out_valid, 1);
    chk("nop_add_in1", n.alu_in1, 7);
    cyc();
    chk("nop_add_gone", n.out_valid, 0);
    chk("sb_final_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
